io_input_con: RTL and testbench

- Input-side counterpart of the LED/seven-segment output controller: the path from board inputs to the CPU.
- Samples 16 slide switches and 5 push keys, synchronises and debounces every input, and latches key-press events as sticky flags.
- Returns switch or key status on the CPU read-data bus when the memory/IO decoder asserts SwitchCtrl or KeyCtrl.
- Sits beside the output controller in the MMIO region; its read_data is muxed into the load path.

---
 rtl/io_pkg.sv | 14 +
 rtl/io_debounce.sv | 30 +++
 rtl/io_input_con.sv | 68 ++++++
 tb/tb_io_input_con.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared defaults and key status word layout for the board input controller.
package io_pkg;
   localparam int DEF_DEBOUNCE_CYCLES = 2000000;
   localparam int DEF_SW_W = 16;
   localparam int DEF_KEY_W = 5;
   localparam int PEND_LSB = 0;
   localparam int LEVEL_LSB = 8;

   function automatic logic [31:0] key_word(input logic [7:0] pend, input logic [7:0] lvl);
      key_word = '0;
      key_word[PEND_LSB+:8] = pend;
      key_word[LEVEL_LSB+:8] = lvl;
   endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser plus debounce counter for one asynchronous input bit.
module io_debounce
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rstn,
   input  logic raw,
   output logic stable
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic s1, s2;
   logic [CW-1:0] cnt;

   // cnt never passes DEBOUNCE_CYCLES-1: it clears on agreement or on commit
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) {s1, s2, stable, cnt} <= '0;
      else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == stable) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= s2;
            cnt <= '0;
         end
         else cnt <= cnt + CW'(1);
      end
endmodule

// File: rtl/io_input_con.sv
// io_input_con: debounced switch/key inputs, sticky key-press flags and registered MMIO read port.
// Define IO_INPUT_IRQ_EN to build the registered key-event interrupt; otherwise irq is tied 0.
module io_input_con
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SW_W = DEF_SW_W,
   parameter int KEY_W = DEF_KEY_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [SW_W-1:0]   switch_in,
   input  logic [KEY_W-1:0]  key_in,
   input  logic              SwitchCtrl,
   input  logic              KeyCtrl,
   input  logic              read_en,
   output logic [31:0]       read_data,
   output logic              irq
);
   logic [SW_W+KEY_W-1:0] raw, stable_all;
   logic [SW_W-1:0] sw_stable;
   logic [KEY_W-1:0] key_stable, key_prev, pending, pending_nx, rise;
   logic key_rd;
   logic [31:0] rd_nx;

   assign raw = {key_in, switch_in};
   assign sw_stable = stable_all[SW_W-1:0];
   assign key_stable = stable_all[SW_W+:KEY_W];

   for (genvar i = 0; i < SW_W + KEY_W; i++) begin : g_db
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .rstn   (rstn),
         .raw    (raw[i]),
         .stable (stable_all[i])
      );
   end

   // a new rise wins over a same-cycle clearing read so the event is kept
   always_comb begin
      rise = key_stable & ~key_prev;
      key_rd = read_en & KeyCtrl & ~SwitchCtrl;
      pending_nx = (key_rd ? '0 : pending) | rise;
      rd_nx = !read_en ? read_data :
              SwitchCtrl ? 32'(sw_stable) :
              KeyCtrl ? key_word(8'(pending), 8'(key_stable)) : '0;
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         key_prev <= '0;
         pending <= '0;
         read_data <= '0;
      end
      else begin
         key_prev <= key_stable;
         pending <= pending_nx;
         read_data <= rd_nx;
      end

`ifdef IO_INPUT_IRQ_EN
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) irq <= 1'b0;
      else irq <= |pending;
`else
   assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_io_input_con.sv
// tb_io_input_con: scoreboard bench for io_input_con with DEBOUNCE_CYCLES=4.
// Read expectations are queued as each read is issued and popped when read_data is valid.
module tb_io_input_con;
   localparam int DC = 4;
`ifdef IO_INPUT_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic clk = 0, rstn = 0;
   logic [15:0] switch_in = '0;
   logic [4:0] key_in = '0;
   logic SwitchCtrl = 0, KeyCtrl = 0, read_en = 0;
   logic [31:0] read_data;
   logic irq;
   int n_cmp = 0, n_bad = 0;
   logic [31:0] exp_q[$];
   string tag_q[$];

   io_input_con #(.DEBOUNCE_CYCLES(DC), .SW_W(16), .KEY_W(5)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .switch_in  (switch_in),
      .key_in     (key_in),
      .SwitchCtrl (SwitchCtrl),
      .KeyCtrl    (KeyCtrl),
      .read_en    (read_en),
      .read_data  (read_data),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic s, input logic k, input logic [31:0] exp, input string tag);
      SwitchCtrl = s;
      KeyCtrl = k;
      read_en = 1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      tick();
      read_en = 0;
      SwitchCtrl = 0;
      KeyCtrl = 0;
      chk(tag_q.pop_front(), read_data, exp_q.pop_front());
   endtask

   initial begin
      #3;
      chk("rst_rdata", read_data, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      tick(2);
      rstn = 1;
      tick(2);
      // switch debounce: stable changes on the 6th edge after the raw change
      switch_in = 16'hA5A5;
      tick(4);
      rd(1, 0, 32'h0, "sw_early");
      tick();
      rd(1, 0, 32'h0000A5A5, "sw_late");
      // 3-cycle glitch on key 2 is rejected
      key_in[2] = 1;
      tick(3);
      key_in[2] = 0;
      tick(8);
      rd(0, 1, 32'h0, "glitch");
      // press, read-to-clear, release
      key_in[0] = 1;
      tick(10);
      key_in[0] = 0;
      rd(0, 1, 32'h00000101, "press_rd1");
      chk("press_irq_hold", 32'(irq), 32'(IRQ_ON));
      rd(0, 1, 32'h00000100, "press_rd2");
      chk("press_irq_fall", 32'(irq), 32'h0);
      tick(8);
      rd(0, 1, 32'h0, "press_rd3");
      // collision: key 4 pending sets on the same edge as the clearing read
      key_in[4] = 1;
      tick(6);
      rd(0, 1, 32'h00001000, "coll_rd1");
      rd(0, 1, 32'h00001010, "coll_rd2");
      key_in[4] = 0;
      tick(8);
      rd(0, 1, 32'h0, "coll_rd3");
      // priority: both selects return switches and leave pending intact
      key_in[1:0] = 2'b11;
      tick(8);
      chk("prio_irq", 32'(irq), 32'(IRQ_ON));
      rd(1, 1, 32'h0000A5A5, "prio_sw");
      rd(0, 1, 32'h00000303, "prio_key");
      key_in[1:0] = 2'b00;
      tick(8);
      rd(0, 1, 32'h0, "prio_clr");
      // reset mid-debounce with a pending flag and irq active
      key_in[2] = 1;
      tick(8);
      key_in[2] = 0;
      key_in[3] = 1;
      tick(4);
      rstn = 0;
      #1;
      chk("mid_rst_rdata", read_data, 32'h0);
      chk("mid_rst_pend", 32'(dut.pending), 32'h0);
      chk("mid_rst_irq", 32'(irq), 32'h0);
      @(posedge clk);
      #1;
      rstn = 1;
      tick(5);
      rd(0, 1, 32'h0, "post_rst_early");
      rd(0, 1, 32'h00000800, "post_rst_level");
      chk("post_rst_irq0", 32'(irq), 32'h0);
      rd(0, 1, 32'h00000808, "post_rst_pend");
      chk("post_rst_irq1", 32'(irq), 32'(IRQ_ON));
      tick();
      chk("post_rst_irq2", 32'(irq), 32'h0);
      key_in = '0;
      chk("sb_drain", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
